// File: rtl/panel_switch_conditioner.sv
// Synchronises, debounces and polarity-normalises the PDP-8/e front-panel switches and keys.
// Optional key auto-repeat for EXAM/DEP is built when `PANEL_AUTOREPEAT_EN is defined.
module panel_switch_conditioner #(
  parameter int TICK_CYCLES  = 500000,
  parameter int STABLE_TICKS = 4,
  parameter int REPEAT_TICKS = 50
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [11:0] srn,
  input  logic        halt_raw,
  input  logic        sstep_raw,
  input  logic        dep_raw,
  input  logic        examn,
  input  logic        contn,
  input  logic        addr_loadn,
  input  logic        extd_addrn,
  input  logic        clearn,
  output logic [11:0] sr,
  output logic        halt,
  output logic        single_step,
  output logic        dep,
  output logic        exam,
  output logic        cont,
  output logic        addr_load,
  output logic        extd_addr,
  output logic        clear,
  output logic        armed
);

  localparam int N_IN = 20;
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int SW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_TICKS - 1);

  if (TICK_CYCLES < 1 || STABLE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_param
    $error("panel_switch_conditioner: all timing parameters must be >= 1");
  end

  // Bit map: [11:0] switch register, 12 halt, 13 single step, [19:14] momentary keys
  logic [N_IN-1:0] raw_s;
  logic [N_IN-1:0] sync1_r;
  logic [N_IN-1:0] sync2_r;
  logic [N_IN-1:0] deb_r;
  logic [SW-1:0]   stab_cnt_r [N_IN];
  logic [TW-1:0]   tick_cnt_r;
  logic            tick_s;
  logic [13:0]     level_r;
  logic [5:0]      key_s;
  logic [5:0]      key_prev_r;
  logic [5:0]      rise_s;
  logic [5:0]      rep_fire_s;
  logic [5:0]      pulse_r;
  logic            armed_r;

  assign raw_s  = {~clearn, ~extd_addrn, ~addr_loadn, ~contn, ~examn,
                   dep_raw, sstep_raw, halt_raw, ~srn};
  assign tick_s = (tick_cnt_r == TICK_LAST);
  assign key_s  = deb_r[19:14];
  assign rise_s = key_s & ~key_prev_r;

  // Two-flop synchroniser on every normalised input
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Debounce sample-tick prescaler
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  // Per-input stability counters; a state flips only after STABLE_TICKS disagreeing ticks
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      deb_r <= '0;
      for (int i = 0; i < N_IN; i++) stab_cnt_r[i] <= '0;
    end else if (tick_s) begin
      for (int i = 0; i < N_IN; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          stab_cnt_r[i] <= '0;
        end else if (stab_cnt_r[i] == STABLE_LAST) begin
          deb_r[i]      <= ~deb_r[i];
          stab_cnt_r[i] <= '0;
        end else begin
          stab_cnt_r[i] <= stab_cnt_r[i] + SW'(1);
        end
      end
    end
  end

`ifdef PANEL_AUTOREPEAT_EN
  localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rep_cnt_r [2];

  // Repeat fires on the tick that completes a full period of continuous hold (dep, exam only)
  always_comb begin
    rep_fire_s = 6'b0;
    for (int k = 0; k < 2; k++) begin
      if (tick_s && key_s[k] && key_prev_r[k] && (rep_cnt_r[k] == REPEAT_LAST)) begin
        rep_fire_s[k] = 1'b1;
      end else begin
        rep_fire_s[k] = 1'b0;
      end
    end
  end

  // Repeat period counters restart on press and clear on release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 2; k++) rep_cnt_r[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (rise_s[k] || !key_s[k]) begin
          rep_cnt_r[k] <= '0;
        end else if (tick_s) begin
          rep_cnt_r[k] <= (rep_cnt_r[k] == REPEAT_LAST) ? '0 : rep_cnt_r[k] + RW'(1);
        end
      end
    end
  end
`else
  assign rep_fire_s = 6'b0;
`endif

  // Arm only once every key is settled released, so a key held through reset cannot fire
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      armed_r <= 1'b0;
    end else if (tick_s && (key_s == 6'b0) && (sync2_r[19:14] == 6'b0)) begin
      armed_r <= 1'b1;
    end
  end

  // Registered level copies and press pulses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level_r    <= '0;
      key_prev_r <= '0;
      pulse_r    <= '0;
    end else begin
      level_r    <= deb_r[13:0];
      key_prev_r <= key_s;
      pulse_r    <= armed_r ? (rise_s | rep_fire_s) : 6'b0;
    end
  end

  assign sr          = level_r[11:0];
  assign halt        = level_r[12];
  assign single_step = level_r[13];
  assign dep         = pulse_r[0];
  assign exam        = pulse_r[1];
  assign cont        = pulse_r[2];
  assign addr_load   = pulse_r[3];
  assign extd_addr   = pulse_r[4];
  assign clear       = pulse_r[5];
  assign armed       = armed_r;

endmodule

// File: tb/tb_panel_switch_conditioner.sv
// Scoreboard bench for panel_switch_conditioner: expected key pulses (key, clk index) are
// queued when a key is driven and matched as pulses appear; levels are checked at known clks.
module tb_panel_switch_conditioner;
  localparam int TICK = 4;
  localparam int STABLE = 3;
  localparam int REPEAT = 5;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [11:0] srn;
  logic        halt_raw, sstep_raw, dep_raw, examn, contn, addr_loadn, extd_addrn, clearn;
  logic [11:0] sr;
  logic        halt, single_step, dep, exam, cont, addr_load, extd_addr, clear, armed;

  panel_switch_conditioner #(.TICK_CYCLES(TICK), .STABLE_TICKS(STABLE), .REPEAT_TICKS(REPEAT)) dut (
    .clk(clk), .resetn(resetn), .srn(srn), .halt_raw(halt_raw), .sstep_raw(sstep_raw),
    .dep_raw(dep_raw), .examn(examn), .contn(contn), .addr_loadn(addr_loadn),
    .extd_addrn(extd_addrn), .clearn(clearn), .sr(sr), .halt(halt), .single_step(single_step),
    .dep(dep), .exam(exam), .cont(cont), .addr_load(addr_load), .extd_addr(extd_addr),
    .clear(clear), .armed(armed));

  always #5 clk = ~clk;

  // Clock edges since reset release: edge k makes cyc == k
  int cyc;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else cyc <= cyc + 1;
  end

  typedef struct { int key; int cyc; } ev_t;
  ev_t sb_q[$];
  ev_t ev;
  int vectors = 0;
  int miscompares = 0;
  logic [5:0] pulses_s;
  assign pulses_s = {clear, extd_addr, addr_load, cont, exam, dep};

  task automatic check_val(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Clk index of the pulse for an input changed just after edge e
  function automatic int exp_cyc(input int e);
    int t1;
    t1 = ((e + 3 + TICK - 1) / TICK) * TICK;
    return t1 + (STABLE - 1) * TICK + 1;
  endfunction

  task automatic set_key(input int k, input bit p);
    case (k)
      0: dep_raw = p;
      1: examn = ~p;
      2: contn = ~p;
      3: addr_loadn = ~p;
      4: extd_addrn = ~p;
      5: clearn = ~p;
      default: ;
    endcase
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic hold_keys(input logic [5:0] mask, input int n);
    int e, first;
    @(posedge clk); #1;
    e = cyc;
    first = exp_cyc(e);
    for (int k = 0; k < 6; k++) if (mask[k]) begin
      set_key(k, 1'b1);
      sb_q.push_back('{k, first});
    end
`ifdef PANEL_AUTOREPEAT_EN
    for (int k = 0; k < 2; k++) if (mask[k]) begin
      for (int t = first + REPEAT * TICK; t - 1 <= exp_cyc(e + n) - 1; t += REPEAT * TICK)
        sb_q.push_back('{k, t});
    end
`endif
    repeat (n) @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) if (mask[k]) set_key(k, 1'b0);
    repeat (4 * STABLE * TICK) @(posedge clk);
  endtask

  // Pulse monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (resetn) begin
      for (int k = 0; k < 6; k++) begin
        if (pulses_s[k]) begin
          if (sb_q.size() == 0) begin
            check_val($sformatf("unexpected_pulse_key%0d", k), pulses_s[k], 0);
          end else begin
            ev = sb_q.pop_front();
            check_val("pulse_key", k, ev.key);
            check_val($sformatf("pulse_cyc_key%0d", k), cyc, ev.cyc);
          end
        end
      end
    end
  end

  initial begin
    int e;
    srn = 12'hFFF; halt_raw = 1'b0; sstep_raw = 1'b0; dep_raw = 1'b0;
    examn = 1'b1; contn = 1'b1; addr_loadn = 1'b1; extd_addrn = 1'b1; clearn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_sr", sr, 0);
    check_val("rst_armed", armed, 0);
    check_val("rst_halt", halt, 0);
    check_val("rst_sstep", single_step, 0);
    check_val("rst_pulses", pulses_s, 0);
    @(negedge clk) resetn = 1'b1;

    // Arming on the first tick
    wait_cyc(3);
    check_val("armed_before_tick", armed, 0);
    wait_cyc(4);
    check_val("armed_after_tick", armed, 1);
    check_val("sr_idle", sr, 0);

    // Held EXAM gives one pulse
    hold_keys(6'b000010, 100);

    // One-tick CONT glitch is rejected, then a real press
    @(posedge clk); #1;
    contn = 1'b0;
    repeat (TICK) @(posedge clk);
    #1;
    contn = 1'b1;
    repeat (24) @(posedge clk);
    hold_keys(6'b000100, 20);

    // Switch register, HALT level and a short glitch on bit 0
    @(posedge clk); #1;
    e = cyc;
    srn = 12'o5252;
    halt_raw = 1'b1;
    wait_cyc(exp_cyc(e) - 1);
    check_val("sr_before_settle", sr, 0);
    wait_cyc(exp_cyc(e));
    check_val("sr_settled", sr, 12'o2525);
    check_val("halt_on", halt, 1);
    check_val("sstep_off", single_step, 0);
    @(posedge clk); #1;
    srn[0] = 1'b1;
    repeat (2 * TICK) @(posedge clk);
    #1;
    srn[0] = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check_val("sr_glitch_ignored", sr, 12'o2525);
    e = cyc;
    srn = 12'hFFF;
    halt_raw = 1'b0;
    sstep_raw = 1'b1;
    wait_cyc(exp_cyc(e));
    check_val("sr_released", sr, 0);
    check_val("halt_off", halt, 0);
    check_val("sstep_on", single_step, 1);

    // Simultaneous DEP + EXTD ADDR, then ADDR LOAD held long
    hold_keys(6'b010001, 12);
    hold_keys(6'b001000, 40);

    // CLEAR held through a mid-run reset
    @(posedge clk); #1;
    clearn = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check_val("midrst_armed", armed, 0);
    check_val("midrst_sstep", single_step, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    wait_cyc(40);
    check_val("held_clear_not_armed", armed, 0);
    @(posedge clk); #1;
    e = cyc;
    clearn = 1'b1;
    wait_cyc(exp_cyc(e) + 2 * TICK);
    check_val("armed_after_clear_release", armed, 1);
    hold_keys(6'b100000, 20);

    repeat (20) @(posedge clk);
    check_val("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
